dsp_mac_sequencer: RTL and testbench

//   Upstream controller for DSP_48E1 configured as a multiply-accumulate engine (FIR dot product).

---
 rtl/dsp_mac_sequencer_pkg.sv | 28 ++
 rtl/dsp_ctrl_skew.sv | 31 +++
 rtl/dsp_mac_sequencer.sv | 147 ++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared types and DSP_48E1 control constants for the MAC sequencer.
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int SAMPLE_W = 25;
  localparam int COEF_W   = 18;
  localparam int A_W      = 30;
  localparam int P_W      = 48;

  // opmode = {Z[2:0], Y[1:0], X[1:0]}
  localparam logic [6:0] OPM_MAC_FIRST   = 7'h05;
  localparam logic [6:0] OPM_MAC_ACC     = 7'h25;
  localparam logic [6:0] OPM_IDLE        = 7'h00;
  localparam logic [3:0] ALUMODE_ADD     = 4'b0000;
  localparam logic [4:0] INMODE_DEFAULT  = 5'b00000;
  localparam logic [2:0] CARRYINSEL_ZERO = 3'b000;

  function automatic logic [A_W-1:0] sext_a(input logic [SAMPLE_W-1:0] x);
    return {{(A_W-SAMPLE_W){x[SAMPLE_W-1]}}, x};
  endfunction

endpackage

// File: rtl/dsp_ctrl_skew.sv
// WIDTH x DEPTH delay line that clears to zero; DEPTH=0 is a plain wire.
module dsp_ctrl_skew #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_reg [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
        end else begin
          stage_reg[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end

      assign dout = stage_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Feeds a DSP_48E1 MAC with TAPS products per accepted sample, then captures
// the drained accumulator and offers it on a valid/ready result stream.
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int TAPS        = 8,
  parameter int PIPE_LAT    = 3,
  parameter int OPMODE_SKEW = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [24:0]               s_data,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [17:0]               coef_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [47:0]               m_data,
  output logic                      busy,
  output logic [29:0]               dsp_a,
  output logic [17:0]               dsp_b,
  output logic [6:0]                dsp_opmode,
  output logic [3:0]                dsp_alumode,
  output logic [4:0]                dsp_inmode,
  output logic [2:0]                dsp_carryinsel,
  input  logic [47:0]               dsp_p
);

  localparam int CW = $clog2(TAPS);
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t            state_reg, state_next;
  logic [CW-1:0]     tap_reg, tap_next;
  logic [DW-1:0]     drain_reg, drain_next;
  logic [24:0]       dline_reg [TAPS];
  logic [17:0]       coef_reg  [TAPS];
  logic [47:0]       m_data_reg;
  logic [6:0]        opm_src;
  logic              accept;
  logic              coef_wr;
  logic              tap_last;
  logic              drain_last;

  assign accept     = s_valid && (state_reg == IDLE);
  assign coef_wr    = coef_we && (state_reg == IDLE);
  assign tap_last   = (tap_reg == CW'(TAPS - 1));
  assign drain_last = (drain_reg == DW'(PIPE_LAT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      tap_reg   <= '0;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      tap_reg   <= tap_next;
      drain_reg <= drain_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tap_next   = tap_reg;
    drain_next = drain_reg;
    case (state_reg)
      IDLE: begin
        if (s_valid) begin
          state_next = MAC;
          tap_next   = '0;
        end
      end
      MAC: begin
        if (tap_last) begin
          state_next = DRAIN;
          drain_next = '0;
        end else begin
          tap_next = tap_reg + CW'(1);
        end
      end
      DRAIN: begin
        if (drain_last) state_next = OUT;
        else            drain_next = drain_reg + DW'(1);
      end
      OUT: begin
        if (m_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A coefficient written in the same cycle as a sample accept is already
  // in place when MAC starts reading the bank on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        dline_reg[i] <= '0;
        coef_reg[i]  <= '0;
      end
    end else begin
      if (accept) begin
        dline_reg[0] <= s_data;
        for (int i = 1; i < TAPS; i++) dline_reg[i] <= dline_reg[i-1];
      end
      if (coef_wr) coef_reg[coef_addr] <= coef_data;
    end
  end

  // The last DRAIN cycle is exactly when P reflects the final issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  m_data_reg <= '0;
    else if (state_reg == DRAIN && drain_last)   m_data_reg <= dsp_p;
  end

  always_comb begin
    opm_src = OPM_IDLE;
    dsp_a   = '0;
    dsp_b   = '0;
    if (state_reg == MAC) begin
      opm_src = (tap_reg == '0) ? OPM_MAC_FIRST : OPM_MAC_ACC;
      dsp_a   = sext_a(dline_reg[tap_reg]);
      dsp_b   = coef_reg[tap_reg];
    end
  end

  // Opmode is registered inside the DSP one stage later than A/B, so it is
  // delayed here to line up with the product it applies to.
  dsp_ctrl_skew #(
    .WIDTH (7),
    .DEPTH (OPMODE_SKEW)
  ) u_opm_skew (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (opm_src),
    .dout  (dsp_opmode)
  );

  assign s_ready        = (state_reg == IDLE);
  assign m_valid        = (state_reg == OUT);
  assign busy           = (state_reg != IDLE);
  assign m_data         = m_data_reg;
  assign dsp_alumode    = ALUMODE_ADD;
  assign dsp_inmode     = INMODE_DEFAULT;
  assign dsp_carryinsel = CARRYINSEL_ZERO;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Randomised and directed checks of dsp_mac_sequencer against a dot-product
// reference model, with a behavioural DSP_48E1 MAC pipeline closing the loop.
module tb_dsp_mac_sequencer;

  localparam int TAPS     = 4;
  localparam int PIPE_LAT = 3;
  localparam int SKEW     = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [24:0] s_data = '0;
  logic        coef_we = 1'b0;
  logic [1:0]  coef_addr = '0;
  logic [17:0] coef_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [47:0] m_data;
  logic        busy;
  logic [29:0] dsp_a;
  logic [17:0] dsp_b;
  logic [6:0]  dsp_opmode;
  logic [3:0]  dsp_alumode;
  logic [4:0]  dsp_inmode;
  logic [2:0]  dsp_carryinsel;
  logic [47:0] dsp_p;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  longint mdl_d [TAPS];
  longint mdl_c [TAPS];

  always #5 clk = ~clk;

  dsp_mac_sequencer #(
    .TAPS        (TAPS),
    .PIPE_LAT    (PIPE_LAT),
    .OPMODE_SKEW (SKEW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .coef_we        (coef_we),
    .coef_addr      (coef_addr),
    .coef_data      (coef_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .busy           (busy),
    .dsp_a          (dsp_a),
    .dsp_b          (dsp_b),
    .dsp_opmode     (dsp_opmode),
    .dsp_alumode    (dsp_alumode),
    .dsp_inmode     (dsp_inmode),
    .dsp_carryinsel (dsp_carryinsel),
    .dsp_p          (dsp_p)
  );

  // DSP_48E1 with AREG=BREG=1, MREG=1, PREG=1, OPMODEREG=1, all CE high.
  logic [29:0]        a_r   = '0;
  logic [17:0]        b_r   = '0;
  logic [6:0]         opm_r = '0;
  logic signed [47:0] m_r   = '0;
  logic signed [47:0] p_r   = '0;

  always @(posedge clk) begin
    a_r   <= dsp_a;
    b_r   <= dsp_b;
    opm_r <= dsp_opmode;
    m_r   <= 48'($signed(a_r[24:0]) * $signed(b_r));
    p_r   <= ((opm_r[6:4] == 3'b010) ? p_r : 48'sd0) +
             ((opm_r[1:0] == 2'b01)  ? m_r : 48'sd0);
  end
  assign dsp_p = p_r;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] model_result();
    longint acc = 0;
    for (int k = 0; k < TAPS; k++) acc += mdl_c[k] * mdl_d[k];
    return acc[47:0];
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < TAPS; k++) begin
      mdl_d[k] = 0;
      mdl_c[k] = 0;
    end
  endfunction

  task automatic write_coef(input int addr, input logic [17:0] val);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = 2'(addr);
    coef_data = val;
    @(negedge clk);
    coef_we   = 1'b0;
    mdl_c[addr] = longint'($signed(val));
  endtask

  task automatic send(input logic [24:0] x, input int hold, input bit chk_lat, input bit mac_wr);
    int n;
    int cyc;
    logic [47:0] exp;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = x;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      check("s_ready_timeout", 64'(s_ready), 64'd1);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int k = TAPS - 1; k > 0; k--) mdl_d[k] = mdl_d[k-1];
    mdl_d[0] = longint'($signed(x));
    exp = model_result();
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = 25'($urandom);
    cyc = 1;
    while (!m_valid && cyc < 60) begin
      if (chk_lat) begin
        if (cyc == 1) check("dsp_a_first", 64'(dsp_a), 64'({{5{x[24]}}, x}));
        if (cyc >= 1 + SKEW && cyc < 1 + SKEW + TAPS)
          check("dsp_opmode", 64'(dsp_opmode), (cyc == 1 + SKEW) ? 64'h05 : 64'h25);
      end
      if (mac_wr && cyc == 2) begin
        coef_we   = 1'b1;
        coef_addr = 2'd0;
        coef_data = 18'd100;
      end else begin
        coef_we = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    coef_we = 1'b0;
    if (!m_valid) begin
      check("m_valid_timeout", 64'(m_valid), 64'd1);
      return;
    end
    if (chk_lat) check("latency", 64'(cyc), 64'(TAPS + PIPE_LAT + 1));
    check("m_data", 64'(m_data), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_m_valid", 64'(m_valid), 64'd1);
      check("hold_m_data", 64'(m_data), 64'(exp));
      check("hold_s_ready", 64'(s_ready), 64'd0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("m_valid_drop", 64'(m_valid), 64'd0);
    check("s_ready_back", 64'(s_ready), 64'd1);
    txn++;
    $display("txn %0d: sample %0h result %0h expected %0h hold %0d", txn, x, m_data, exp, hold);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 64'(s_ready), 64'd1);
    check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_m_data"},  64'(m_data), 64'd0);
    check({tag, "_busy"},    64'(busy), 64'd0);
    check({tag, "_dsp_a"},   64'(dsp_a), 64'd0);
    check({tag, "_dsp_b"},   64'(dsp_b), 64'd0);
    check({tag, "_opmode"},  64'(dsp_opmode), 64'd0);
  endtask

  task automatic reset_mid_mac(input logic [24:0] x);
    int n;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = x;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    check("mid_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (3) @(negedge clk);
    check_reset_outputs("mid_rst_hold");
    rst_n = 1'b1;
    model_clear();
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_valid) n++;
    end
    check("no_result_after_rst", 64'(n), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    model_clear();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("alumode", 64'(dsp_alumode), 64'd0);
    check("inmode", 64'(dsp_inmode), 64'd0);
    check("carryinsel", 64'(dsp_carryinsel), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // coef {1,2,3,4}: 10,20,30,40 -> 10,40,100,200
    for (int k = 0; k < TAPS; k++) write_coef(k, 18'(k + 1));
    send(25'd10, 0, 1'b1, 1'b0);
    send(25'd20, 0, 1'b0, 1'b0);
    send(25'd30, 0, 1'b0, 1'b0);
    send(25'd40, 0, 1'b1, 1'b0);

    // signed path: coef {-3,0,0,0}; -5 -> 15, then 7 -> -21
    write_coef(0, 18'h3FFFD);
    for (int k = 1; k < TAPS; k++) write_coef(k, 18'd0);
    send(25'h1FFFFFB, 0, 1'b0, 1'b0);
    check("sign_pos15", 64'(m_data), 64'd15);
    send(25'd7, 0, 1'b0, 1'b0);
    check("sign_neg21", 64'(m_data), 64'h0000_FFFF_FFFF_FFEB);

    // result backpressure
    send(25'd123, 5, 1'b0, 1'b0);

    // coefficient write during MAC is dropped; same write in IDLE lands
    for (int k = 0; k < TAPS; k++) write_coef(k, 18'(2 * k + 1));
    send(25'd9, 0, 1'b0, 1'b1);
    write_coef(0, 18'd100);
    send(25'd9, 0, 1'b0, 1'b0);

    // reset mid-MAC clears delay line and coefficients
    reset_mid_mac(25'd55);
    for (int k = 0; k < TAPS; k++) write_coef(k, 18'($urandom));
    send(25'($urandom), 0, 1'b0, 1'b0);

    // randomised samples, coefficient updates and backpressure
    for (int t = 0; t < 24; t++) begin
      wc = int'($urandom_range(0, 2));
      for (int w = 0; w < wc; w++) write_coef(int'($urandom_range(0, TAPS - 1)), 18'($urandom));
      send(25'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
